// File: rtl/uart_reg_sys.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_sys
// Description : UART-controlled 16x8 register file and ALU. Command frames
//               received on RX_IN write or read registers or run an ALU
//               operation, and responses are transmitted on TX_OUT.
//               8 data bits, XNOR parity, one stop bit, PRESCALE clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_sys #(
   parameter int DATA_WIDTH     = 8,
   parameter int ALU_FUN_WIDTH  = 4,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int ADDR_WIDTH     = 4,
   parameter int PRESCALE       = 32
) (
   input  logic UART_CLK,
   input  logic RST,
   input  logic RX_IN,
   output logic TX_OUT,
   output logic PAR_ERR,
   output logic STP_ERR
);
   localparam int CNT_W  = $clog2(PRESCALE);
   localparam int RXB_W  = $clog2(DATA_WIDTH);
   localparam int TXB_W  = $clog2(DATA_WIDTH + 3);
   localparam int FRM_W  = DATA_WIDTH + 3;
   localparam int RF_DEP = 2 ** REG_ADDR_WIDTH;
   localparam logic [CNT_W-1:0]      c_sample   = CNT_W'(PRESCALE / 2 - 1);
   localparam logic [CNT_W-1:0]      c_bitend   = CNT_W'(PRESCALE - 1);
   localparam logic [RXB_W-1:0]      c_rx_last  = RXB_W'(DATA_WIDTH - 1);
   localparam logic [TXB_W-1:0]      c_tx_last  = TXB_W'(FRM_W - 1);
   localparam logic [DATA_WIDTH-1:0] c_cmd_wr   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] c_cmd_rd   = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] c_cmd_alu  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] c_cmd_alun = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {CMD_IDLE, CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR,
                             CMD_ALU_A, CMD_ALU_B, CMD_ALU_FUN, CMD_SEND} cmd_state_t;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

   // receiver
   rx_state_t               r_rx_st, w_rx_nx;
   logic [CNT_W-1:0]        r_rx_cnt;
   logic [RXB_W-1:0]        r_rx_bit;
   logic [DATA_WIDTH-1:0]   r_rx_shift;
   logic                    r_rx_par, r_rx_d, r_rx_valid, r_par_err, r_stp_err;
   logic                    w_rx_smp, w_rx_end, w_rx_par_ok, w_rx_err;
   logic [DATA_WIDTH-1:0]   w_rx_byte;
   logic [REG_ADDR_WIDTH-1:0] w_rx_addr;
   // command / register file
   cmd_state_t              r_cmd_st, w_cmd_nx;
   logic [DATA_WIDTH-1:0]   r_rf [RF_DEP];
   logic [REG_ADDR_WIDTH-1:0] r_addr, w_rf_waddr;
   logic [DATA_WIDTH-1:0]   r_resp, w_resp_val, w_alu, w_a, w_b;
   logic [3:0]              w_fun;
   logic                    w_rf_we, w_addr_load, w_resp_load, w_tx_start;
   // transmitter
   tx_state_t               r_tx_st, w_tx_nx;
   logic [CNT_W-1:0]        r_tx_cnt;
   logic [TXB_W-1:0]        r_tx_bit;
   logic [FRM_W-1:0]        r_tx_frame;
   logic                    w_tx_end;

   assign w_rx_smp    = (r_rx_cnt == c_sample);
   assign w_rx_end    = (r_rx_cnt == c_bitend);
   assign w_rx_par_ok = (r_rx_par == ~^r_rx_shift);
   assign w_rx_err    = r_par_err | r_stp_err;
   assign w_rx_byte   = r_rx_shift;   // stable long after the valid pulse
   assign w_rx_addr   = REG_ADDR_WIDTH'(w_rx_byte[ADDR_WIDTH-1:0]);
   assign w_fun       = 4'(w_rx_byte[ALU_FUN_WIDTH-1:0]);
   assign w_a         = r_rf[0];
   assign w_b         = r_rf[1];
   assign w_tx_end    = (r_tx_cnt == c_bitend);
   assign TX_OUT      = (r_tx_st == TX_BUSY) ? r_tx_frame[0] : 1'b1;
   assign PAR_ERR     = r_par_err;
   assign STP_ERR     = r_stp_err;

   // state registers of all three FSMs
   always_ff @(posedge UART_CLK or negedge RST) begin
      if (!RST) begin
         r_rx_st  <= RX_IDLE;
         r_cmd_st <= CMD_IDLE;
         r_tx_st  <= TX_IDLE;
      end else begin
         r_rx_st  <= w_rx_nx;
         r_cmd_st <= w_cmd_nx;
         r_tx_st  <= w_tx_nx;
      end
   end

   // receiver next state: a high start-bit sample is a false start
   always_comb begin
      w_rx_nx = r_rx_st;
      case (r_rx_st)
         RX_IDLE:  if (r_rx_d && !RX_IN) w_rx_nx = RX_START;
         RX_START: if (w_rx_smp && RX_IN) w_rx_nx = RX_IDLE;
                   else if (w_rx_end) w_rx_nx = RX_DATA;
         RX_DATA:  if (w_rx_end && r_rx_bit == c_rx_last) w_rx_nx = RX_PAR;
         RX_PAR:   if (w_rx_end) w_rx_nx = RX_STOP;
         RX_STOP:  if (w_rx_smp) w_rx_nx = RX_IDLE;
         default:  w_rx_nx = RX_IDLE;
      endcase
   end

   // receiver datapath; the edge-detect cycle counts as cycle 0 of the start bit
   always_ff @(posedge UART_CLK or negedge RST) begin
      if (!RST) begin
         r_rx_d <= 1'b1; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_shift <= '0;
         r_rx_par <= 1'b0; r_rx_valid <= 1'b0; r_par_err <= 1'b0; r_stp_err <= 1'b0;
      end else begin
         r_rx_d     <= RX_IN;
         r_rx_valid <= 1'b0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
         if (r_rx_st == RX_IDLE) r_rx_cnt <= CNT_W'(1);
         else if (w_rx_end)      r_rx_cnt <= '0;
         else                    r_rx_cnt <= r_rx_cnt + CNT_W'(1);
         if (r_rx_st != RX_DATA) r_rx_bit <= '0;
         else if (w_rx_end)      r_rx_bit <= r_rx_bit + RXB_W'(1);
         if (w_rx_smp) begin
            case (r_rx_st)
               RX_DATA: r_rx_shift <= {RX_IN, r_rx_shift[DATA_WIDTH-1:1]};
               RX_PAR:  r_rx_par   <= RX_IN;
               RX_STOP: begin
                  r_rx_valid <= RX_IN & w_rx_par_ok;
                  r_par_err  <= ~w_rx_par_ok;
                  r_stp_err  <= ~RX_IN;
               end
               default: ;
            endcase
         end
      end
   end

   // ALU on RF[0] (A) and RF[1] (B), result truncated to the data width
   always_comb begin
      w_alu = '0;
      case (w_fun)
         4'd0: w_alu = w_a + w_b;
         4'd1: w_alu = w_a - w_b;
         4'd2: w_alu = w_a * w_b;
         4'd3: w_alu = (w_b == '0) ? '0 : w_a / w_b;
         4'd4: w_alu = w_a & w_b;
         4'd5: w_alu = w_a | w_b;
         4'd6: w_alu = w_a ^ w_b;
         4'd7: w_alu = ~(w_a & w_b);
         4'd8: w_alu = DATA_WIDTH'(w_a == w_b);
         4'd9: w_alu = DATA_WIDTH'(w_a > w_b);
         default: w_alu = '0;
      endcase
   end

   // command decoder; a receive error abandons any partial command
   always_comb begin
      w_cmd_nx    = r_cmd_st;
      w_rf_we     = 1'b0;
      w_rf_waddr  = r_addr;
      w_addr_load = 1'b0;
      w_resp_load = 1'b0;
      w_resp_val  = r_rf[w_rx_addr];
      w_tx_start  = 1'b0;
      if (w_rx_err) begin
         w_cmd_nx = CMD_IDLE;
      end else begin
         case (r_cmd_st)
            CMD_IDLE: if (r_rx_valid) begin
               if (w_rx_byte == c_cmd_wr)        w_cmd_nx = CMD_WR_ADDR;
               else if (w_rx_byte == c_cmd_rd)   w_cmd_nx = CMD_RD_ADDR;
               else if (w_rx_byte == c_cmd_alu)  w_cmd_nx = CMD_ALU_A;
               else if (w_rx_byte == c_cmd_alun) w_cmd_nx = CMD_ALU_FUN;
            end
            CMD_WR_ADDR: if (r_rx_valid) begin w_addr_load = 1'b1; w_cmd_nx = CMD_WR_DATA; end
            CMD_WR_DATA: if (r_rx_valid) begin w_rf_we = 1'b1; w_cmd_nx = CMD_IDLE; end
            CMD_RD_ADDR: if (r_rx_valid) begin w_resp_load = 1'b1; w_cmd_nx = CMD_SEND; end
            CMD_ALU_A: if (r_rx_valid) begin
               w_rf_we = 1'b1; w_rf_waddr = '0; w_cmd_nx = CMD_ALU_B;
            end
            CMD_ALU_B: if (r_rx_valid) begin
               w_rf_we = 1'b1; w_rf_waddr = REG_ADDR_WIDTH'(1); w_cmd_nx = CMD_ALU_FUN;
            end
            CMD_ALU_FUN: if (r_rx_valid) begin
               w_resp_load = 1'b1; w_resp_val = w_alu; w_cmd_nx = CMD_SEND;
            end
            CMD_SEND: if (r_tx_st == TX_IDLE) begin w_tx_start = 1'b1; w_cmd_nx = CMD_IDLE; end
            default: w_cmd_nx = CMD_IDLE;
         endcase
      end
   end

   // register file, pending address and response byte
   always_ff @(posedge UART_CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < RF_DEP; i++) r_rf[i] <= '0;
         r_addr <= '0;
         r_resp <= '0;
      end else begin
         if (w_rf_we)     r_rf[w_rf_waddr] <= w_rx_byte;
         if (w_addr_load) r_addr <= w_rx_addr;
         if (w_resp_load) r_resp <= w_resp_val;
      end
   end

   // transmitter next state: busy for exactly one frame
   always_comb begin
      w_tx_nx = r_tx_st;
      case (r_tx_st)
         TX_IDLE: if (w_tx_start) w_tx_nx = TX_BUSY;
         TX_BUSY: if (w_tx_end && r_tx_bit == c_tx_last) w_tx_nx = TX_IDLE;
         default: w_tx_nx = TX_IDLE;
      endcase
   end

   // transmitter shift register: bit 0 of the frame drives the line
   always_ff @(posedge UART_CLK or negedge RST) begin
      if (!RST) begin
         r_tx_cnt <= '0; r_tx_bit <= '0; r_tx_frame <= '1;
      end else if (r_tx_st == TX_IDLE) begin
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         if (w_tx_start) r_tx_frame <= {1'b1, ~^r_resp, r_resp, 1'b0};
      end else if (w_tx_end) begin
         r_tx_cnt   <= '0;
         r_tx_bit   <= r_tx_bit + TXB_W'(1);
         r_tx_frame <= {1'b1, r_tx_frame[FRM_W-1:1]};
      end else begin
         r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_reg_sys.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_sys
// Description : Scoreboard bench for uart_reg_sys. Command tasks update a
//               register-file model and queue expected response bytes; an
//               independent monitor decodes TX_OUT frames and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_sys;
   localparam int PRESCALE = 32;

   logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
   logic tx, par_err, stp_err;

   uart_reg_sys #(.PRESCALE(PRESCALE)) dut (
      .UART_CLK(clk), .RST(rst_n), .RX_IN(rx),
      .TX_OUT(tx), .PAR_ERR(par_err), .STP_ERR(stp_err));

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int par_pulses = 0, stp_pulses = 0, tx_starts = 0, aborted = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rf_m [16];
   logic tx_prev = 1'b1;
   bit mon_busy = 0, mon_abort = 0;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // error pulse and TX start-edge counters
   always @(negedge clk) begin
      if (par_err) par_pulses++;
      if (stp_err) stp_pulses++;
      if (rst_n && tx_prev && !tx) tx_starts++;
      tx_prev = tx;
   end

   task automatic mon_wait(int n);
      repeat (n) begin
         @(negedge clk);
         if (!rst_n) mon_abort = 1;
      end
   endtask

   // monitor: decode every TX frame and compare with the scoreboard
   initial begin : monitor
      logic [7:0] d, e;
      logic st, p, s;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            mon_busy = 1; mon_abort = 0;
            mon_wait(PRESCALE / 2);
            st = tx;
            for (int i = 0; i < 8; i++) begin mon_wait(PRESCALE); d[i] = tx; end
            mon_wait(PRESCALE); p = tx;
            mon_wait(PRESCALE); s = tx;
            if (mon_abort) aborted++;
            else if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL tx_unexpected: got frame 0x%0h expected no frame", d);
            end else begin
               e = exp_q.pop_front();
               check("tx_start_bit", st, 0);
               check("tx_data", d, e);
               check("tx_parity", p, ~^e);
               check("tx_stop", s, 1);
            end
            mon_busy = 0;
         end
      end
   end

   function automatic logic [7:0] alu_m(logic [3:0] f, logic [7:0] a, logic [7:0] b);
      int ia, ib, r;
      ia = a; ib = b;
      case (f)
         4'd0: r = ia + ib;
         4'd1: r = ia - ib;
         4'd2: r = ia * ib;
         4'd3: r = (ib == 0) ? 0 : ia / ib;
         4'd4: r = ia & ib;
         4'd5: r = ia | ib;
         4'd6: r = ia ^ ib;
         4'd7: r = ~(ia & ib);
         4'd8: r = (ia == ib) ? 1 : 0;
         4'd9: r = (ia > ib) ? 1 : 0;
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   task automatic send_byte(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         rx = f[i];
         repeat (PRESCALE) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic do_write(logic [7:0] a, logic [7:0] d);
      send_byte(8'hAA); send_byte(a); send_byte(d);
      rf_m[a[3:0]] = d;
   endtask

   task automatic do_read(logic [7:0] a);
      send_byte(8'hBB);
      exp_q.push_back(rf_m[a[3:0]]);
      send_byte(a);
   endtask

   task automatic do_alu_full(logic [7:0] a, logic [7:0] b, logic [7:0] f);
      send_byte(8'hCC); send_byte(a); send_byte(b);
      rf_m[0] = a; rf_m[1] = b;
      exp_q.push_back(alu_m(f[3:0], a, b));
      send_byte(f);
   endtask

   task automatic do_alu(logic [7:0] f);
      send_byte(8'hDD);
      exp_q.push_back(alu_m(f[3:0], rf_m[0], rf_m[1]));
      send_byte(f);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy || tx !== 1'b1) && n < 2000) begin
         @(negedge clk); n++;
      end
      if (n >= 2000) begin
         n_checks++; n_errors++;
         $display("FAIL wait_idle: got %0d pending after %0d cycles expected 0", exp_q.size(), n);
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin : stim
      int p0, s0, t0, n;
      logic [7:0] a, d, f;
      for (int i = 0; i < 16; i++) rf_m[i] = 8'h00;
      repeat (5) @(negedge clk);
      check("reset_tx_out", tx, 1);
      check("reset_par_err", par_err, 0);
      check("reset_stp_err", stp_err, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      do_read(8'h05); wait_idle();
      t0 = tx_starts;
      do_write(8'h0B, 8'h16);
      repeat (50) @(negedge clk);
      check("write_no_tx", tx_starts, t0);
      do_read(8'h0B); wait_idle();

      do_alu_full(8'h0A, 8'h03, 8'h00); wait_idle();
      do_alu(8'h02); wait_idle();
      do_write(8'h01, 8'h00);
      do_alu(8'h03); wait_idle();

      // parity error on the address frame of a read
      p0 = par_pulses; s0 = stp_pulses; t0 = tx_starts;
      send_byte(8'hBB); send_byte(8'h0B, 1, 0);
      repeat (50) @(negedge clk);
      check("par_err_pulse", par_pulses - p0, 1);
      check("par_err_no_stp", stp_pulses - s0, 0);
      check("par_err_no_tx", tx_starts, t0);
      do_read(8'h0B); wait_idle();

      // short glitch must not start a frame
      p0 = par_pulses; s0 = stp_pulses; t0 = tx_starts;
      @(negedge clk); rx = 1'b0;
      repeat (10) @(negedge clk); rx = 1'b1;
      repeat (400) @(negedge clk);
      check("glitch_no_par", par_pulses - p0, 0);
      check("glitch_no_stp", stp_pulses - s0, 0);
      check("glitch_no_tx", tx_starts, t0);

      // stop bit low on the address frame of a read
      send_byte(8'hBB); send_byte(8'h0B, 0, 1);
      repeat (50) @(negedge clk);
      check("stp_err_pulse", stp_pulses - s0, 1);
      check("stp_err_no_par", par_pulses - p0, 0);
      check("stp_err_no_tx", tx_starts, t0);
      do_read(8'hFB); wait_idle();

      // randomized command mix
      for (int k = 0; k < 16; k++) begin
         a = 8'($urandom); d = 8'($urandom); f = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 3))
            0: do_write(a, d);
            1: do_read(a);
            2: do_alu_full(a, d, f);
            default: do_alu(f);
         endcase
         wait_idle();
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end

      // reset while a response is being transmitted
      send_byte(8'hBB); send_byte(8'h0B);
      n = 0;
      while (!mon_busy && n < 100) begin @(negedge clk); n++; end
      check("rst_tx_started", mon_busy, 1);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_tx_out_high", tx, 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) rf_m[i] = 8'h00;
      wait_idle();
      check("rst_aborted_frame", aborted, 1);
      do_read(8'h0B); wait_idle();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
